// File: rtl/hs_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hs_arb_pkg: shared types and defaults for the hiscore arbiter.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package hs_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_VBL = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_GRANT    = 3'd3,
      ST_RELEASE  = 3'd4
   } hs_arb_state_t;

   localparam int unsigned HS_SETTLE_DEF      = 16;
   localparam int unsigned HS_VBL_TIMEOUT_DEF = 1000000;
   localparam int unsigned HS_DIM_DEF         = 300000000;

   // The core stays frozen from the end of the vblank wait until the port is handed back.
   function automatic logic arb_holds_pause(input hs_arb_state_t s);
      return (s == ST_SETTLE) || (s == ST_GRANT) || (s == ST_RELEASE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pause_toggle_dim.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pause_toggle_dim: pause button toggle and dim-video timer.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pause_toggle_dim
   import hs_arb_pkg::*;
#(
   parameter int unsigned DIM_CYCLES = HS_DIM_DEF
)(
   input  logic clk,
   input  logic reset,
   input  logic btn_pause,
   output logic user_pause,
   output logic dim_video
);

   localparam int unsigned DIM_W = $clog2(DIM_CYCLES) + 1;
   localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(DIM_CYCLES);

   logic             btn_dly_q;
   logic             user_pause_q, user_pause_d;
   logic [DIM_W-1:0] dim_cnt_q, dim_cnt_d;
   logic             dim_video_q, dim_video_d;
   logic             btn_rise;

   always_comb begin
      btn_rise     = btn_pause & ~btn_dly_q;
      user_pause_d = user_pause_q ^ btn_rise;
      dim_cnt_d    = '0;
      if (user_pause_q) begin
         dim_cnt_d = (dim_cnt_q >= DIM_MAX) ? DIM_MAX : dim_cnt_q + 1'b1;
      end
      dim_video_d  = user_pause_q && (dim_cnt_d >= DIM_MAX);
   end

   // Button delay resets high so a button held through reset is not seen as a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_dly_q    <= 1'b1;
         user_pause_q <= 1'b0;
         dim_cnt_q    <= '0;
         dim_video_q  <= 1'b0;
      end else begin
         btn_dly_q    <= btn_pause;
         user_pause_q <= user_pause_d;
         dim_cnt_q    <= dim_cnt_d;
         dim_video_q  <= dim_video_d;
      end
   end

   // Next-state value, so the parent's registered pause moves on the toggle edge.
   assign user_pause = user_pause_d;
   assign dim_video  = dim_video_q;

endmodule
`default_nettype wire

// File: rtl/hs_pause_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hs_pause_arbiter: freezes the core at vblank for hiscore RAM     |
// | access and merges user/OSD pause. Revision: 1.0                  |
// +------------------------------------------------------------------+
module hs_pause_arbiter
   import hs_arb_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = HS_SETTLE_DEF,
   parameter int unsigned VBL_TIMEOUT   = HS_VBL_TIMEOUT_DEF,
   parameter int unsigned DIM_CYCLES    = HS_DIM_DEF
)(
   input  logic clk,
   input  logic reset,
   input  logic hs_req,
   output logic hs_grant,
   input  logic btn_pause,
   input  logic osd_open,
   input  logic osd_pause_en,
   input  logic vblank,
   output logic pause,
   output logic dim_video
);

   localparam int unsigned WAIT_W = $clog2(VBL_TIMEOUT) + 1;
   localparam int unsigned SETL_W = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(VBL_TIMEOUT - 1);
   localparam logic [SETL_W-1:0] SETL_LAST = SETL_W'(SETTLE_CYCLES - 1);

   hs_arb_state_t     state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [SETL_W-1:0] settle_cnt_q, settle_cnt_d;
   logic              vbl_dly_q;
   logic              hs_grant_q, hs_grant_d;
   logic              pause_q, pause_d;
   logic              vbl_rise;
   logic              user_pause_nxt;

   pause_toggle_dim #(
      .DIM_CYCLES (DIM_CYCLES)
   ) u_pause_toggle_dim (
      .clk        (clk),
      .reset      (reset),
      .btn_pause  (btn_pause),
      .user_pause (user_pause_nxt),
      .dim_video  (dim_video)
   );

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      settle_cnt_d = settle_cnt_q;
      vbl_rise     = vblank & ~vbl_dly_q;

      case (state_q)
         ST_IDLE: begin
            if (hs_req) begin
               state_d    = ST_WAIT_VBL;
               wait_cnt_d = '0;
            end
         end
         ST_WAIT_VBL: begin
            if (vbl_rise || (wait_cnt_q == WAIT_LAST)) begin
               state_d      = ST_SETTLE;
               settle_cnt_d = '0;
            end else if (!hs_req) begin
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == SETL_LAST) begin
               state_d = ST_GRANT;
            end else if (!hs_req) begin
               state_d = ST_RELEASE;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         ST_GRANT: begin
            if (!hs_req) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      hs_grant_d = (state_d == ST_GRANT);
      pause_d    = arb_holds_pause(state_d) | user_pause_nxt | (osd_open & osd_pause_en);
   end

   // vblank delay resets high so a vblank level present at reset is not an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         settle_cnt_q <= '0;
         vbl_dly_q    <= 1'b1;
         hs_grant_q   <= 1'b0;
         pause_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         vbl_dly_q    <= vblank;
         hs_grant_q   <= hs_grant_d;
         pause_q      <= pause_d;
      end
   end

   assign hs_grant = hs_grant_q;
   assign pause    = pause_q;

endmodule
`default_nettype wire
